period_meter: RTL and testbench

Measures the period and high time of a slow, asynchronous square wave in `fastclk` cycles. Typical sources are the output of the team's clock divider or any external slow strobe. It sits on the 50 MHz board clock next to the divider. It reports each completed measurement with a one-cycle valid pulse, which the display and debug logic use to confirm divider settings and to detect a stalled source.

---
 rtl/period_meter_pkg.sv | 15 +
 rtl/sync_rise.sv | 35 +++
 rtl/period_meter.sv | 114 +++++++++++
 tb/tb_period_meter.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/period_meter_pkg.sv
// period_meter_pkg
// Shared definitions for the period meter: measurement FSM state encoding
// and the default counter width / stall limit. The defaults are also read by
// the clock divider's configuration, so change them with care.
package period_meter_pkg;

    localparam int DEF_CNT_W   = 26;
    localparam int DEF_TIMEOUT = 2**26 - 1;

    typedef enum logic {
        IDLE,
        MEASURE
    } state_t;

endpackage

// File: rtl/sync_rise.sv
// sync_rise
// Two-flop synchronizer for a slow asynchronous input followed by a history
// flop, giving the synchronized level and a one-cycle rising-edge strobe.
// Falling edges are not reported.
//   fastclk  in   sampling clock
//   reset    in   synchronous active-high reset, clears all three flops
//   async_in in   asynchronous input
//   level    out  synchronized level (second synchronizer stage)
//   rise     out  high for the one cycle where level is 1 and was 0 before
module sync_rise (
    input  logic fastclk,
    input  logic reset,
    input  logic async_in,
    output logic level,
    output logic rise
);

    logic s1, s2, prev;

    always_ff @(posedge fastclk) begin
        if (reset) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
        end else begin
            s1   <= async_in;
            s2   <= s1;
            prev <= s2;
        end
    end

    assign level = s2;
    assign rise  = s2 & ~prev;

endmodule

// File: rtl/period_meter.sv
// period_meter
// Measures period and high time of a slow square wave in fastclk cycles.
// A measurement window runs from one synchronized rising edge to the next;
// each completed window is reported with a one-cycle period_valid pulse.
// If no rising edge arrives within TIMEOUT cycles the source is flagged as
// stalled and the meter waits idle for the next edge.
//   fastclk      in   board clock, the only clock
//   reset        in   synchronous active-high reset (also clears synchronizer)
//   sig_in       in   asynchronous square wave
//   clear        in   synchronous soft clear (synchronizer left running)
//   period       out  last measured period
//   high_time    out  last measured high time
//   period_valid out  one-cycle pulse when period/high_time update
//   locked       out  valid measurement seen since reset, clear or timeout
//   timeout      out  sticky stall flag, cleared by next capture
module period_meter
    import period_meter_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             fastclk,
    input  logic             reset,
    input  logic             sig_in,
    input  logic             clear,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_valid,
    output logic             locked,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

    logic             level, rise;
    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx, hcnt, hcnt_nx;
    logic             capture, stall;

    sync_rise u_sync (
        .fastclk  (fastclk),
        .reset    (reset),
        .async_in (sig_in),
        .level    (level),
        .rise     (rise)
    );

    always_ff @(posedge fastclk) begin
        if (reset || clear) state <= IDLE;
        else                state <= state_nx;
    end

    // Counters start at 1 on the rise cycle, so cnt equals the number of
    // cycles since that rise when the next one arrives. The rise cycle always
    // has level = 1, hence hcnt also starts at 1.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        hcnt_nx  = hcnt;
        capture  = 1'b0;
        stall    = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_nx = MEASURE;
                    cnt_nx   = ONE;
                    hcnt_nx  = ONE;
                end
            end
            MEASURE: begin
                if (rise) begin
                    // A rise on the limit cycle still counts as a capture.
                    capture = 1'b1;
                    cnt_nx  = ONE;
                    hcnt_nx = ONE;
                end else if (cnt == TO_CNT) begin
                    stall    = 1'b1;
                    state_nx = IDLE;
                end else begin
                    cnt_nx  = cnt + ONE;
                    hcnt_nx = hcnt + {{(CNT_W-1){1'b0}}, level};
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge fastclk) begin
        if (reset || clear) begin
            cnt          <= '0;
            hcnt         <= '0;
            period       <= '0;
            high_time    <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            cnt          <= cnt_nx;
            hcnt         <= hcnt_nx;
            period_valid <= capture;
            if (capture) begin
                period    <= cnt;
                high_time <= hcnt;
                locked    <= 1'b1;
                timeout   <= 1'b0;
            end else if (stall) begin
                locked    <= 1'b0;
                timeout   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_period_meter.sv
module tb_period_meter;

    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 64;
    localparam int MAXE    = 12000;

    logic             fastclk = 1'b0;
    logic             reset   = 1'b0;
    logic             sig_in  = 1'b0;
    logic             clear   = 1'b0;
    logic [CNT_W-1:0] period, high_time;
    logic             period_valid, locked, timeout;

    period_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .fastclk      (fastclk),
        .reset        (reset),
        .sig_in       (sig_in),
        .clear        (clear),
        .period       (period),
        .high_time    (high_time),
        .period_valid (period_valid),
        .locked       (locked),
        .timeout      (timeout)
    );

    always #5 fastclk = ~fastclk;

    int total = 0;
    int bad   = 0;

    // Reference model: edges are numbered; sig_at[e] is the input sampled at
    // edge e. The measuring logic sees the input two edges late (three for
    // the history bit), except that nothing sampled at or before the last
    // reset edge is visible. A window [r, t) between two rises gives
    // period = t - r and high_time = number of edges in it seeing a 1.
    bit  sig_at [MAXE];
    bit  lvl_at [MAXE];
    int  e      = 0;
    int  rst_e  = 0;
    int  last_r = 0;
    bit  meas   = 1'b0;
    int  m_per  = 0;
    int  m_hi   = 0;
    bit  m_vld  = 1'b0;
    bit  m_lock = 1'b0;
    bit  m_to   = 1'b0;
    bit  arm_clear = 1'b0;

    function automatic bit seen(int k, int delay);
        return (k - delay > rst_e) ? sig_at[k - delay] : 1'b0;
    endfunction

    function automatic bit rise_at(int k);
        return seen(k, 2) & ~seen(k, 3);
    endfunction

    task automatic model_edge(bit clr, bit rst);
        bit r;
        r = rise_at(e);
        lvl_at[e] = seen(e, 2);
        m_vld = 1'b0;
        if (rst || clr) begin
            meas = 0; m_per = 0; m_hi = 0; m_lock = 0; m_to = 0;
            if (rst) rst_e = e;
        end else if (meas && r) begin
            m_per = e - last_r;
            m_hi  = 0;
            for (int k = last_r; k < e; k++) m_hi += int'(lvl_at[k]);
            m_vld = 1; m_lock = 1; m_to = 0;
            last_r = e;
        end else if (meas && (e - last_r == TIMEOUT)) begin
            meas = 0; m_to = 1; m_lock = 0;
        end else if (!meas && r) begin
            meas = 1; last_r = e;
        end
    endtask

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s edge=%0d got=%0d expected=%0d", tag, e, got, exp);
        end
    endtask

    task automatic tick(bit sig, bit clr, bit rst);
        bit c;
        c = clr;
        if (e + 2 >= MAXE) begin
            $display("FAIL cycle_budget edge=%0d", e);
            $fatal(1, "cycle budget exceeded");
        end
        sig_at[e + 1] = sig;
        // Optionally land a clear exactly on the next predicted rise edge.
        if (arm_clear && rise_at(e + 1)) begin
            c = 1'b1;
            arm_clear = 1'b0;
        end
        sig_in = sig; clear = c; reset = rst;
        @(posedge fastclk);
        e++;
        model_edge(c, rst);
        @(negedge fastclk);
        chk("period",       32'(period),       32'(m_per));
        chk("high_time",    32'(high_time),    32'(m_hi));
        chk("period_valid", 32'(period_valid), 32'(m_vld));
        chk("locked",       32'(locked),       32'(m_lock));
        chk("timeout",      32'(timeout),      32'(m_to));
    endtask

    task automatic hold(bit v, int n);
        for (int i = 0; i < n; i++) tick(v, 1'b0, 1'b0);
    endtask

    task automatic wave(int hi, int lo, int reps);
        for (int r = 0; r < reps; r++) begin
            hold(1'b1, hi);
            hold(1'b0, lo);
        end
    endtask

    initial begin
        int hi, lo;
        // reset state
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b1);
        hold(1'b0, 3);
        // steady square wave
        wave(10, 10, 6);
        // duty changes
        wave(5, 15, 4);
        wave(15, 5, 4);
        // stall after lock, then relock at period 30
        hold(1'b0, 90);
        wave(15, 15, 4);
        // rise exactly at the limit, then one past it
        wave(32, 32, 4);
        wave(33, 32, 4);
        wave(10, 10, 3);
        // clear coinciding with a rise, then relock
        arm_clear = 1'b1;
        wave(10, 10, 4);
        // reset while input high and locked
        hold(1'b1, 4);
        tick(1'b1, 1'b0, 1'b1);
        hold(1'b1, 6);
        hold(1'b0, 10);
        wave(10, 10, 3);
        // minimum period
        wave(1, 1, 6);
        // randomized waveforms, some longer than the stall limit,
        // with occasional soft clears
        for (int n = 0; n < 60; n++) begin
            hi = int'($urandom_range(1, 36));
            lo = int'($urandom_range(1, 36));
            if ($urandom_range(0, 9) == 0) arm_clear = 1'b1;
            wave(hi, lo, int'($urandom_range(1, 3)));
            if ($urandom_range(0, 14) == 0) tick(1'b0, 1'b1, 1'b0);
        end
        hold(1'b0, TIMEOUT + 8);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
